// File: rtl/uart_pkg.sv
// Shared constants and state encoding for the UART receive path.
package uart_pkg;
  localparam int DEFAULT_CLK_FREQ = 100_000_000;
  localparam int DEFAULT_BAUD     = 9600;
  localparam int DATA_W           = 8;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_STOP      = 3'd3,
    S_WAIT_HIGH = 3'd4
  } rx_state_e;
endpackage

// File: rtl/uart_rx_unit_if.sv
// Byte handshake and error strobes between the receiver and the CPU-side peripheral.
interface uart_rx_unit_if;
  import uart_pkg::*;

  logic              rx_ack;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              frame_err;
  logic              overrun;

  // Receiver side drives the data and strobes.
  modport slave  (input rx_ack, output rx_data, rx_valid, frame_err, overrun);
  // Consumer side acknowledges.
  modport master (output rx_ack, input rx_data, rx_valid, frame_err, overrun);
endinterface

// File: rtl/uart_rx_unit_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input, reset to a chosen level.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);
  logic r_meta;
  logic r_sync;

  // Two-stage capture; the first flop may go metastable, the second resolves it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;
endmodule

// File: rtl/uart_rx_unit.sv
// 8N1 UART receiver: mid-bit sampling off a down-counter, one-byte holding register
// with valid/ack, single-cycle framing-error and overrun strobes.
module uart_rx_unit
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = DEFAULT_CLK_FREQ,
  parameter int BAUD     = DEFAULT_BAUD
) (
  input  logic           sys_clk,
  input  logic           reset,
  input  logic           UART_RX,
  uart_rx_unit_if.slave  rx_if
);
  localparam int BIT_CYCLES  = CLK_FREQ / BAUD;
  localparam int HALF_CYCLES = BIT_CYCLES / 2;
  localparam int CNT_W       = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int IDX_W       = $clog2(DATA_W);

  localparam logic [CNT_W-1:0] HALF_LD  = CNT_W'(HALF_CYCLES - 1);
  localparam logic [CNT_W-1:0] BIT_LD   = CNT_W'(BIT_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

  rx_state_e         r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [IDX_W-1:0]  r_idx, w_idx_nxt;
  logic [DATA_W-1:0] r_shift, w_shift_nxt;
  logic [DATA_W-1:0] r_data;
  logic              r_valid, r_ferr, r_ovr;
  logic              w_rxs, w_tick, w_stop_ok, w_stop_bad;

  // Idle-high line: synchronizer resets to 1 so reset release never looks like a start edge.
  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .i_clk   (sys_clk),
    .i_rst_n (reset),
    .i_d     (UART_RX),
    .o_q     (w_rxs)
  );

  assign w_tick = (r_cnt == '0);

  // Frame state, bit timer, bit index and shift register.
  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_shift <= w_shift_nxt;
    end
  end

  // Next-state: every decision is taken when the bit timer reads zero.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_shift_nxt = r_shift;
    w_stop_ok   = 1'b0;
    w_stop_bad  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_rxs) begin
          w_cnt_nxt   = HALF_LD;
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        if (!w_tick) w_cnt_nxt = r_cnt - 1'b1;
        else if (w_rxs) w_state_nxt = S_IDLE;   // too short to be a start bit
        else begin
          w_cnt_nxt   = BIT_LD;
          w_idx_nxt   = '0;
          w_state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        if (!w_tick) w_cnt_nxt = r_cnt - 1'b1;
        else begin
          w_shift_nxt[r_idx] = w_rxs;
          w_idx_nxt          = r_idx + 1'b1;
          w_cnt_nxt          = BIT_LD;
          if (r_idx == LAST_IDX) w_state_nxt = S_STOP;
        end
      end
      S_STOP: begin
        if (!w_tick) w_cnt_nxt = r_cnt - 1'b1;
        else if (w_rxs) begin
          w_stop_ok   = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_stop_bad  = 1'b1;
          w_state_nxt = S_WAIT_HIGH;               // ride out a break without re-flagging
        end
      end
      S_WAIT_HIGH: begin
        if (w_rxs) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Holding register: an ack on the delivery cycle frees the slot for the new byte.
  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_ferr <= w_stop_bad;
      r_ovr  <= 1'b0;
      if (w_stop_ok) begin
        if (!r_valid || rx_if.rx_ack) begin
          r_data  <= r_shift;
          r_valid <= 1'b1;
        end else begin
          r_ovr <= 1'b1;
        end
      end else if (rx_if.rx_ack) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign rx_if.rx_data   = r_data;
  assign rx_if.rx_valid  = r_valid;
  assign rx_if.frame_err = r_ferr;
  assign rx_if.overrun   = r_ovr;
endmodule

// File: tb/tb_uart_rx_unit.sv
// Directed bench for uart_rx_unit at a reduced rate: 16 clocks per bit, 8 to mid-bit.
module tb_uart_rx_unit;
  localparam int BIT  = 16;   // 1600 / 100
  localparam int HALF = 8;
  localparam int LAT  = 2 + HALF + 9 * BIT;   // start edge to stop-sample edge

  logic sys_clk = 1'b0;
  logic reset   = 1'b0;
  logic UART_RX = 1'b1;

  uart_rx_unit_if u_if ();

  uart_rx_unit #(.CLK_FREQ(1600), .BAUD(100)) dut (
    .sys_clk (sys_clk),
    .reset   (reset),
    .UART_RX (UART_RX),
    .rx_if   (u_if)
  );

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  int last_t0 = -1;
  int rise_cyc = -1;
  int fe_cnt = 0;
  int ov_cnt = 0;
  logic prev_v = 1'b0;
  int checks = 0;
  int fails = 0;

  always @(posedge sys_clk) cyc <= cyc + 1;

  // Strobe high-cycle counters and rx_valid rise time.
  always @(negedge sys_clk) begin
    if (u_if.frame_err) fe_cnt <= fe_cnt + 1;
    if (u_if.overrun)   ov_cnt <= ov_cnt + 1;
    if (u_if.rx_valid && !prev_v) rise_cyc <= cyc;
    prev_v <= u_if.rx_valid;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_lvl, input int stop_len);
    @(negedge sys_clk);
    UART_RX = 1'b0;
    last_t0 = cyc + 1;
    repeat (BIT) @(negedge sys_clk);
    for (int i = 0; i < 8; i++) begin
      UART_RX = b[i];
      repeat (BIT) @(negedge sys_clk);
    end
    UART_RX = stop_lvl;
    repeat (stop_len) @(negedge sys_clk);
    UART_RX = 1'b1;
  endtask

  task automatic wait_valid(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge sys_clk);
      if (u_if.rx_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic ack_byte();
    @(negedge sys_clk);
    u_if.rx_ack = 1'b1;
    @(negedge sys_clk);
    u_if.rx_ack = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int fe0, ov0;
    logic [7:0] b2b [2];
    b2b[0] = 8'hA3;
    b2b[1] = 8'h0F;
    u_if.rx_ack = 1'b0;

    // Reset values
    repeat (3) @(negedge sys_clk);
    chk("rst_data",  u_if.rx_data, 0);
    chk("rst_valid", u_if.rx_valid, 0);
    chk("rst_ferr",  u_if.frame_err, 0);
    chk("rst_ovr",   u_if.overrun, 0);
    reset = 1'b1;
    repeat (4) @(negedge sys_clk);

    // Single byte, latency
    fe0 = fe_cnt; ov0 = ov_cnt; rise_cyc = -1;
    send_frame(8'h55, 1'b1, BIT);
    chk("lat55",   rise_cyc - last_t0, LAT);
    chk("data55",  u_if.rx_data, 8'h55);
    chk("valid55", u_if.rx_valid, 1);
    chk("fe55",    fe_cnt - fe0, 0);
    chk("ov55",    ov_cnt - ov0, 0);
    ack_byte();
    chk("ack55", u_if.rx_valid, 0);

    // Back-to-back frames with a one-cycle ack after each delivery
    fe0 = fe_cnt; ov0 = ov_cnt;
    fork
      begin
        send_frame(8'hA3, 1'b1, BIT);
        send_frame(8'h0F, 1'b1, BIT);
      end
      begin
        for (int k = 0; k < 2; k++) begin
          bit ok;
          wait_valid(400, ok);
          chk("b2b_timeout", ok, 1);
          chk("b2b_data", u_if.rx_data, b2b[k]);
          u_if.rx_ack = 1'b1;
          @(negedge sys_clk);
          u_if.rx_ack = 1'b0;
          chk("b2b_drop", u_if.rx_valid, 0);
        end
      end
    join
    chk("b2b_fe", fe_cnt - fe0, 0);
    chk("b2b_ov", ov_cnt - ov0, 0);

    // Short low glitch is rejected at the start-bit sample
    fe0 = fe_cnt;
    @(negedge sys_clk);
    UART_RX = 1'b0;
    repeat (3) @(negedge sys_clk);
    UART_RX = 1'b1;
    repeat (3 * BIT) @(negedge sys_clk);
    chk("glitch_valid", u_if.rx_valid, 0);
    chk("glitch_fe", fe_cnt - fe0, 0);
    send_frame(8'h81, 1'b1, BIT);
    chk("valid81", u_if.rx_valid, 1);
    chk("data81",  u_if.rx_data, 8'h81);
    ack_byte();

    // Stop bit low, line held low for a while: one framing-error cycle only
    fe0 = fe_cnt;
    send_frame(8'hFF, 1'b0, 3 * BIT);
    repeat (BIT) @(negedge sys_clk);
    chk("ferr_pulses", fe_cnt - fe0, 1);
    chk("ferr_valid",  u_if.rx_valid, 0);
    send_frame(8'h3C, 1'b1, BIT);
    chk("valid3c", u_if.rx_valid, 1);
    chk("data3c",  u_if.rx_data, 8'h3C);
    chk("fe3c",    fe_cnt - fe0, 1);
    ack_byte();

    // Overrun: second byte dropped while the first is unacked
    ov0 = ov_cnt;
    send_frame(8'h11, 1'b1, BIT);
    chk("data11", u_if.rx_data, 8'h11);
    send_frame(8'h22, 1'b1, BIT);
    chk("ovr_pulses", ov_cnt - ov0, 1);
    chk("ovr_data",   u_if.rx_data, 8'h11);
    chk("ovr_valid",  u_if.rx_valid, 1);

    // Ack landing exactly on the stop-sample cycle takes the new byte
    ov0 = ov_cnt;
    last_t0 = -1;
    fork
      send_frame(8'h22, 1'b1, BIT);
      begin : acker
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 400 && !hit; i++) begin
          @(negedge sys_clk);
          if (last_t0 >= 0 && cyc == last_t0 + LAT - 1) hit = 1'b1;
        end
        chk("ack_sync", hit, 1);
        u_if.rx_ack = 1'b1;
        @(negedge sys_clk);
        u_if.rx_ack = 1'b0;
      end
    join
    chk("ackd_data",  u_if.rx_data, 8'h22);
    chk("ackd_valid", u_if.rx_valid, 1);
    chk("ackd_ov",    ov_cnt - ov0, 0);

    // Reset during data bit 4, held until the line is idle again
    last_t0 = -1;
    fork
      send_frame(8'h99, 1'b1, BIT);
      begin : rst_mid
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 400 && !hit; i++) begin
          @(negedge sys_clk);
          if (last_t0 >= 0 && cyc == last_t0 + 5 * BIT + HALF) hit = 1'b1;
        end
        chk("rst_sync", hit, 1);
        reset = 1'b0;
        @(negedge sys_clk);
        chk("mid_rst_data",  u_if.rx_data, 0);
        chk("mid_rst_valid", u_if.rx_valid, 0);
        chk("mid_rst_ferr",  u_if.frame_err, 0);
        chk("mid_rst_ovr",   u_if.overrun, 0);
      end
    join
    fe0 = fe_cnt; ov0 = ov_cnt;
    @(negedge sys_clk);
    reset = 1'b1;
    repeat (2 * BIT) @(negedge sys_clk);
    chk("post_rst_valid", u_if.rx_valid, 0);
    chk("post_rst_fe",    fe_cnt - fe0, 0);
    chk("post_rst_ov",    ov_cnt - ov0, 0);
    send_frame(8'h99, 1'b1, BIT);
    chk("valid99", u_if.rx_valid, 1);
    chk("data99",  u_if.rx_data, 8'h99);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
